// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode, hazard and forward-source signals into the E stage, and the registered E outputs.
// ID_EX_PERF_CNT_EN adds the bubble and forward counters to the bundle.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CONTROL_WIDTH  = 3,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      stall_e, flush_e;
    logic [DATA_WIDTH-1:0]     rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_d, rs2_d, rd_d;
    logic                      reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0]                result_src_d;
    logic [CONTROL_WIDTH-1:0]  alu_control_d;
    logic [1:0]                forward_ae, forward_be;
    logic [DATA_WIDTH-1:0]     alu_result_m, result_w;
    logic [REG_ADDR_WIDTH-1:0] rs1_e, rs2_e, rd_e;
    logic                      reg_write_e, mem_write_e, jump_e, branch_e;
    logic [1:0]                result_src_e;
    logic [CONTROL_WIDTH-1:0]  alu_control_e;
    logic [DATA_WIDTH-1:0]     pc_e, pc_plus4_e, imm_ext_e;
    logic [DATA_WIDTH-1:0]     src_ae, src_be, write_data_e;
    logic                      valid_e;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]               bubble_count_e, fwd_count_e;
`endif
    modport master (
        output stall_e, flush_e, rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d,
        output rs1_d, rs2_d, rd_d, reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d,
        output result_src_d, alu_control_d, forward_ae, forward_be, alu_result_m, result_w,
`ifdef ID_EX_PERF_CNT_EN
        input  bubble_count_e, fwd_count_e,
`endif
        input  rs1_e, rs2_e, rd_e, reg_write_e, mem_write_e, jump_e, branch_e,
        input  result_src_e, alu_control_e, pc_e, pc_plus4_e, imm_ext_e,
        input  src_ae, src_be, write_data_e, valid_e
    );
    modport slave (
        input  stall_e, flush_e, rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d,
        input  rs1_d, rs2_d, rd_d, reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d,
        input  result_src_d, alu_control_d, forward_ae, forward_be, alu_result_m, result_w,
`ifdef ID_EX_PERF_CNT_EN
        output bubble_count_e, fwd_count_e,
`endif
        output rs1_e, rs2_e, rd_e, reg_write_e, mem_write_e, jump_e, branch_e,
        output result_src_e, alu_control_e, pc_e, pc_plus4_e, imm_ext_e,
        output src_ae, src_be, write_data_e, valid_e
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall/flush and execute-side operand forwarding.
// Defining ID_EX_PERF_CNT_EN adds saturating bubble and forward counters.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int CONTROL_WIDTH  = 3,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0]     rd1, rd2, pc, pc_plus4, imm_ext;
        logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
        logic                      reg_write, mem_write, jump, branch, alu_src;
        logic [1:0]                result_src;
        logic [CONTROL_WIDTH-1:0]  alu_control;
        logic                      valid;
    } e_t;

    e_t d, e;

    always_comb begin
        d.rd1         = bus.rd1_d;
        d.rd2         = bus.rd2_d;
        d.pc          = bus.pc_d;
        d.pc_plus4    = bus.pc_plus4_d;
        d.imm_ext     = bus.imm_ext_d;
        d.rs1         = bus.rs1_d;
        d.rs2         = bus.rs2_d;
        d.rd          = bus.rd_d;
        d.reg_write   = bus.reg_write_d;
        d.mem_write   = bus.mem_write_d;
        d.jump        = bus.jump_d;
        d.branch      = bus.branch_d;
        d.alu_src     = bus.alu_src_d;
        d.result_src  = bus.result_src_d;
        d.alu_control = bus.alu_control_d;
        d.valid       = 1'b1;
    end

    // Flush shares the reset path: a bubble is indistinguishable from the reset state.
    always_ff @(posedge clk)
        if (rst || bus.flush_e) e <= '0;
        else if (!bus.stall_e) e <= d;

    // Select 11 falls through to the register value; x0 always reads as zero.
    function automatic logic [DATA_WIDTH-1:0] fwd(
        input logic [1:0]                sel,
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]     rv, m, w
    );
        return rs == '0 ? '0 : sel == 2'b10 ? m : sel == 2'b01 ? w : rv;
    endfunction

    assign bus.src_ae        = fwd(bus.forward_ae, e.rs1, e.rd1, bus.alu_result_m, bus.result_w);
    assign bus.write_data_e  = fwd(bus.forward_be, e.rs2, e.rd2, bus.alu_result_m, bus.result_w);
    assign bus.src_be        = e.alu_src ? e.imm_ext : bus.write_data_e;
    assign bus.rs1_e         = e.rs1;
    assign bus.rs2_e         = e.rs2;
    assign bus.rd_e          = e.rd;
    assign bus.reg_write_e   = e.reg_write;
    assign bus.mem_write_e   = e.mem_write;
    assign bus.jump_e        = e.jump;
    assign bus.branch_e      = e.branch;
    assign bus.result_src_e  = e.result_src;
    assign bus.alu_control_e = e.alu_control;
    assign bus.pc_e          = e.pc;
    assign bus.pc_plus4_e    = e.pc_plus4;
    assign bus.imm_ext_e     = e.imm_ext;
    assign bus.valid_e       = e.valid;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubbles, fwds;
    logic        fwd_hit;

    // Only 01 and 10 are real forwards, so the XOR of the select bits marks them.
    assign fwd_hit = e.valid && !bus.stall_e && (^bus.forward_ae || ^bus.forward_be);

    always_ff @(posedge clk)
        if (rst) begin
            bubbles <= '0;
            fwds    <= '0;
        end else begin
            if (bus.flush_e && bubbles != '1) bubbles <= bubbles + 32'd1;
            if (fwd_hit && fwds != '1) fwds <= fwds + 32'd1;
        end

    assign bus.bubble_count_e = bubbles;
    assign bus.fwd_count_e    = fwds;
`endif
endmodule
